// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for every block that drives or decodes the 3-bit ALU
// operation code. The mode constants live here so that each ALU user
// decodes the same encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_ADD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SUB = 3'b001;
    localparam logic [MODE_W-1:0] MODE_AND = 3'b010;
    localparam logic [MODE_W-1:0] MODE_OR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_XOR = 3'b100;
    localparam logic [MODE_W-1:0] MODE_SLL = 3'b101;
    localparam logic [MODE_W-1:0] MODE_SRL = 3'b110;
    localparam logic [MODE_W-1:0] MODE_SRA = 3'b111;

    // Shift amounts come from the low bits of operand B only.
    localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu32_core.sv
// ---------------------------------------------------------------------------
// alu32_core
// Purely combinational ALU datapath shared by the arbiter's requesters.
//
// Ports
//   a     in  WIDTH  operand A (signed)
//   b     in  WIDTH  operand B (signed); shifts use b[4:0] only
//   mode  in  3      operation code (see alu_pkg)
//   x     out WIDTH  result; add/sub wrap modulo 2^WIDTH
//   zero  out 1      x == 0, for every mode
// ---------------------------------------------------------------------------
module alu32_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  x,
    output logic              zero
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        x = '0;
        case (mode)
            MODE_ADD: x = a + b;
            MODE_SUB: x = a - b;
            MODE_AND: x = a & b;
            MODE_OR:  x = a | b;
            MODE_XOR: x = a ^ b;
            MODE_SLL: x = a << shamt;
            MODE_SRL: x = a >> shamt;
            MODE_SRA: x = $signed(a) >>> shamt;
            default:  x = '0;
        endcase
    end

    assign zero = (x == '0);

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Two requesters share one combinational ALU. A round-robin arbiter picks
// one valid request per cycle and the ALU result is captured in a one-entry
// result register with a valid/ready handshake toward the consumer.
//
// Ports
//   clk          in  1      clock, rising edge
//   rst_n        in  1      asynchronous active-low reset
//   req0_valid   in  1      requester 0 has an operation pending
//   req0_ready   out 1      requester 0's operation accepted this cycle
//   req0_a/_b    in  WIDTH  requester 0 operands
//   req0_mode    in  3      requester 0 operation code
//   req1_*       same as req0_* for requester 1
//   rsp_valid    out 1      result register holds an undelivered result
//   rsp_ready    in  1      consumer takes the result this cycle
//   rsp_id       out 1      requester that owns the result
//   rsp_x        out WIDTH  result
//   rsp_zero     out 1      rsp_x == 0
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [MODE_W-1:0] req0_mode,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [MODE_W-1:0] req1_mode,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_x,
    output logic              rsp_zero
);

    logic              last_grant_reg;
    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic [WIDTH-1:0]  rsp_x_reg;
    logic              rsp_zero_reg;

    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [MODE_W-1:0] alu_mode;
    logic [WIDTH-1:0]  alu_x;
    logic              alu_zero;

    // The register can take a new result when empty or when it is being
    // drained on this same edge. rst_n gates the readies so nothing is
    // handed out while the block is held in reset.
    assign can_accept = rst_n && (!rsp_valid_reg || rsp_ready);

    // Round robin: on a tie the requester that did not win last time goes.
    assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

    assign req0_ready = can_accept && grant0;
    assign req1_ready = can_accept && grant1;
    assign accept     = req0_ready || req1_ready;

    // The operand mux follows the grant; when nothing is granted its output
    // is simply not captured.
    assign sel      = grant1;
    assign alu_a    = sel ? req1_a    : req0_a;
    assign alu_b    = sel ? req1_b    : req0_b;
    assign alu_mode = sel ? req1_mode : req0_mode;

    alu32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (alu_a),
        .b    (alu_b),
        .mode (alu_mode),
        .x    (alu_x),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_x_reg      <= '0;
            rsp_zero_reg   <= 1'b0;
        end else if (accept) begin
            last_grant_reg <= sel;
            rsp_valid_reg  <= 1'b1;
            rsp_id_reg     <= sel;
            rsp_x_reg      <= alu_x;
            rsp_zero_reg   <= alu_zero;
        end else if (rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_x     = rsp_x_reg;
    assign rsp_zero  = rsp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed, self-checking bench for alu_arbiter. Inputs change 1 time unit
// after a rising edge; combinational readies are checked 1 unit later and
// registered outputs 1 unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]        req0_mode, req1_mode;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [WIDTH-1:0]  rsp_x;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_x      (rsp_x),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] x,
                             input logic z, input logic id);
        chk({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
        chk({tag, ".x"},     rsp_x,              x);
        chk({tag, ".zero"},  {31'd0, rsp_zero},  {31'd0, z});
        chk({tag, ".id"},    {31'd0, rsp_id},    {31'd0, id});
        $display("rsp %s: valid=%0b id=%0b x=%h zero=%0b", tag, rsp_valid, rsp_id, rsp_x, rsp_zero);
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, r0});
        chk({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    // Directed single-requester vectors: a, b, mode, expected x, expected zero
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [31:0] x;
        logic        z;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD, 32'h0000_0000, 1'b1};
        vecs[1] = '{32'h0000_0003, 32'h0000_0005, MODE_SUB, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{32'h0000_F0F0, 32'h0000_FF00, MODE_AND, 32'h0000_F000, 1'b0};
        vecs[3] = '{32'h0000_F0F0, 32'h0000_0F0F, MODE_OR,  32'h0000_FFFF, 1'b0};
        vecs[4] = '{32'h0000_0001, 32'h0000_001F, MODE_SLL, 32'h8000_0000, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0024, MODE_SRL, 32'h0800_0000, 1'b0};
        vecs[6] = '{32'h4000_0000, 32'h0000_0001, MODE_SRA, 32'h2000_0000, 1'b0};

        rst_n      = 1'b0;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_mode = MODE_ADD;
        req1_a = '0; req1_b = '0; req1_mode = MODE_ADD;

        // ---- reset state: outputs cleared, no ready while in reset
        #3;
        check_rsp("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        check_rdy("reset", 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single request: 5 - 3
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_mode = MODE_SUB;
        rsp_ready  = 1'b1;
        check_rdy("single", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        check_rsp("single", 1'b1, 32'd2, 1'b0, 1'b0);
        tick();
        chk("drain.valid", {31'd0, rsp_valid}, 32'd0);

        // ---- fresh reset so the first tie is the post-reset one
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();

        // ---- tie after reset: req0 first, then req1 (SRA)
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_mode = MODE_ADD;
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_mode = MODE_SRA;
        check_rdy("tie1", 1'b1, 1'b0);
        tick();
        check_rsp("tie1", 1'b1, 32'd30, 1'b0, 1'b0);
        // req0 moves on to its next op (XOR giving zero) and waits
        req0_a = 32'hFF; req0_b = 32'hFF; req0_mode = MODE_XOR;
        check_rdy("tie2", 1'b0, 1'b1);
        tick();
        check_rsp("tie2", 1'b1, 32'hF800_0000, 1'b0, 1'b1);

        // ---- backpressure: both valid, consumer stalls 3 cycles
        req1_a = 32'd1; req1_b = 32'd33; req1_mode = MODE_SLL;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_rdy("stall", 1'b0, 1'b0);
            tick();
            check_rsp("stall", 1'b1, 32'hF800_0000, 1'b0, 1'b1);
        end
        // drain and refill on one edge; req0 wins since req1 went last
        rsp_ready = 1'b1;
        check_rdy("refill", 1'b1, 1'b0);
        tick();
        check_rsp("xorzero", 1'b1, 32'h0, 1'b1, 1'b0);
        req0_valid = 1'b0;
        check_rdy("shl", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        check_rsp("shl33", 1'b1, 32'd2, 1'b0, 1'b1);

        // ---- remaining modes from requester 0 alone
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1'b1;
            req0_a = vecs[i].a; req0_b = vecs[i].b; req0_mode = vecs[i].mode;
            check_rdy($sformatf("vec%0d", i), 1'b1, 1'b0);
            tick();
            check_rsp($sformatf("vec%0d", i), 1'b1, vecs[i].x, vecs[i].z, 1'b0);
        end
        req0_valid = 1'b0;

        // ---- reset mid-operation: stalled result is discarded immediately
        rsp_ready = 1'b0;
        tick();
        chk("pre_rst.valid", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_rsp("midrst", 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---- streaming: both valid for 10 cycles, ids alternate from 0
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd7;   req0_b = 32'd1; req0_mode = MODE_ADD;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_mode = MODE_SUB;
        for (int i = 0; i < 10; i++) begin
            logic eid;
            eid = logic'(i % 2);
            check_rdy($sformatf("stream%0d", i), !eid, eid);
            tick();
            check_rsp($sformatf("stream%0d", i), 1'b1, eid ? 32'd99 : 32'd8, 1'b0, eid);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("stream_end.valid", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports reqN_valid, input, 1 bit, N=0,1: requester N has an operation pending.
REQ-005 The block SHALL have ports reqN_ready, output, 1 bit: the operation from requester N is accepted this cycle.
REQ-006 The block SHALL have ports reqN_a and reqN_b, input, WIDTH bits each: signed operands A and B.
REQ-007 The block SHALL have port reqN_mode, input, 3 bits: operation code.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: the result register holds an undelivered result.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: the index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_x, output, WIDTH bits: the result.
REQ-012 The block SHALL have port rsp_zero, output, 1 bit: set when rsp_x equals 0.

Function
REQ-013 The block SHALL share one combinational ALU between the two requesters and register each result into a one-entry result register.
REQ-014 The mode encodings SHALL be: 000 add; 001 sub; 010 AND; 011 OR; 100 XOR; 101 logical shift left; 110 logical shift right; 111 arithmetic shift right.
REQ-015 Shift amount SHALL be B[4:0]; B[WIDTH-1:5] SHALL be ignored; add and sub SHALL wrap modulo 2^WIDTH with no carry or overflow output.
REQ-016 rsp_zero SHALL be computed for every mode, not only sub.
REQ-017 The block SHALL be able to accept when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 (drain and refill in the same cycle).
REQ-018 When the block is able to accept and exactly one reqN_valid is set, it SHALL assert reqN_ready for that requester only.
REQ-019 When both are valid, it SHALL grant the requester other than the last-granted one; lastgrant SHALL reset to 1, so req0 wins the first tie.
REQ-020 reqN_ready SHALL be combinational from valids, lastgrant, rsp_valid and rsp_ready; at most one ready SHALL be high per cycle.
REQ-021 On accept, the result register SHALL capture x, zero and id on the same edge; rsp_valid SHALL be 1 from the next cycle (latency 1).
REQ-022 When rsp_valid=1 and rsp_ready=0, rsp_x, rsp_zero and rsp_id SHALL hold stable, and both readies SHALL be 0.
REQ-023 When rsp_ready=1 with no new accept, rsp_valid SHALL fall to 0 on the next edge.
REQ-024 Requesters SHALL hold valid, operands and mode stable until ready; the block SHALL NOT depend on valid being dropped after ready.
REQ-025 Sustained throughput SHALL be one operation per cycle when rsp_ready is held at 1.
REQ-026 lastgrant SHALL update only on an accept.

Reset
REQ-027 With rst_n=0, rsp_valid SHALL be 0, rsp_x SHALL be 0, rsp_zero SHALL be 0, rsp_id SHALL be 0 and lastgrant SHALL be 1, all immediately (asynchronous).
REQ-028 An undelivered result SHALL be discarded by reset; no ready SHALL be asserted while rst_n=0.

Structure
REQ-029 The mode codes SHALL be localparams in shared package alu_pkg, reused by every ALU user.
REQ-030 The ALU datapath SHALL be one combinational sub-module alu32_core (a, b, mode -> x, zero), instantiated once.
REQ-031 The arbiter and result register SHALL live in alu_arbiter; no other sub-modules.

Verification
REQ-032 Single request: req0 a=5, b=3, mode=001, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, x=2, zero=0, id=0.
REQ-033 Tie after reset: both valid, req1 a=0x80000000, b=4, mode=111 -> req0 served first, then req1; x=0xF8000000, id=1.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles with both valid -> outputs stable, readies 0; rsp_ready=1 -> drain and new accept on the same edge.
REQ-035 Zero flag: a=0xFF, b=0xFF, mode=100 -> x=0, zero=1; a=1, b=33, mode=101 -> x=2 (shift uses B[4:0]).
REQ-036 Streaming: both requesters valid for 10 cycles, rsp_ready=1 -> 10 results, ids alternating 0,1,0,...
REQ-037 Reset mid-operation: rst_n low while rsp_valid=1 -> rsp_valid=0 at once; after release, first tie goes to req0.
